// File: rtl/msrh_csu_pipe_mq.sv
// CSR-unit execution pipe (EX0 capture, EX1 regfile read, EX2 CSR read/ALU,
// EX3 CSR write/writeback/done) with an in-order SFENCE.VMA commit-wait queue.
module msrh_csu_pipe_mq #(
  parameter int XLEN          = 64,
  parameter int RV_ENTRY_SIZE = 32,
  parameter int TGT_BUS_SIZE  = 4,
  parameter int RNID_W        = 7,
  parameter int CMT_ID_W      = 6,
  parameter int SFQ_DEPTH     = 4,
  parameter int VADDR_W       = 39
) (
  input  logic                           i_clk,
  input  logic                           i_reset_n,
  input  logic                           i_ex0_valid,
  input  logic [RV_ENTRY_SIZE-1:0]       i_ex0_index,
  input  logic [CMT_ID_W-1:0]            i_ex0_cmt_id,
  input  logic [1:0]                     i_ex0_op,
  input  logic [11:0]                    i_ex0_csr_addr,
  input  logic                           i_ex0_rs1_valid,
  input  logic [RNID_W-1:0]              i_ex0_rs1_rnid,
  input  logic [4:0]                     i_ex0_uimm,
  input  logic                           i_ex0_rs1_is_x0,
  input  logic                           i_ex0_rs2_is_x0,
  input  logic                           i_ex0_is_sfence,
  input  logic                           i_ex0_rd_valid,
  input  logic [RNID_W-1:0]              i_ex0_rd_rnid,
  output logic                           o_ex1_rs1_rd_valid,
  output logic [RNID_W-1:0]              o_ex1_rs1_rnid,
  input  logic [XLEN-1:0]                i_ex2_rs1_data,
  input  logic [TGT_BUS_SIZE-1:0]        i_fwd_valid,
  input  logic [TGT_BUS_SIZE*RNID_W-1:0] i_fwd_rnid,
  input  logic [TGT_BUS_SIZE*XLEN-1:0]   i_fwd_data,
  output logic                           o_csr_rd_valid,
  output logic [11:0]                    o_csr_rd_addr,
  input  logic [XLEN-1:0]                i_csr_rd_data,
  input  logic                           i_csr_rd_error,
  output logic                           o_csr_wr_valid,
  output logic [11:0]                    o_csr_wr_addr,
  output logic [XLEN-1:0]                o_csr_wr_data,
  output logic                           o_ex3_wr_valid,
  output logic [RNID_W-1:0]              o_ex3_wr_rnid,
  output logic [XLEN-1:0]                o_ex3_wr_data,
  output logic                           o_ex3_done,
  output logic [RV_ENTRY_SIZE-1:0]       o_ex3_index,
  output logic [1:0]                     o_ex3_except,
  input  logic                           i_commit_valid,
  input  logic [CMT_ID_W-1:0]            i_commit_cmt_id,
  input  logic                           i_flush,
  output logic                           o_sfence_credit_ok,
  output logic                           o_sfence_valid,
  output logic [VADDR_W-1:0]             o_sfence_vaddr,
  output logic                           o_sfence_rs1_x0,
  output logic                           o_sfence_rs2_x0
);

  // Handshake: issue is valid-only. The pipe never stalls, so there is no
  // ready; the reservation station must hold back an sfence while
  // o_sfence_credit_ok is low, which keeps every EX3 push room in the queue.

  localparam int PW = (SFQ_DEPTH > 1) ? $clog2(SFQ_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [1:0] OP_NONE = 2'd0;
  localparam logic [1:0] OP_RS   = 2'd2;
  localparam logic [1:0] OP_RC   = 2'd3;

  typedef struct packed {
    logic [RV_ENTRY_SIZE-1:0] index;
    logic [CMT_ID_W-1:0]      cmt_id;
    logic [1:0]               op;
    logic [11:0]              csr_addr;
    logic                     rs1_valid;
    logic [RNID_W-1:0]        rs1_rnid;
    logic [4:0]               uimm;
    logic                     rs1_is_x0;
    logic                     rs2_is_x0;
    logic                     is_sfence;
    logic                     rd_valid;
    logic [RNID_W-1:0]        rd_rnid;
  } uop_t;

  uop_t ex0_uop, ex1_uop, ex2_uop;
  logic ex1_valid, ex2_valid, ex3_valid;

  logic [RV_ENTRY_SIZE-1:0] ex3_index;
  logic [CMT_ID_W-1:0]      ex3_cmt_id;
  logic [1:0]               ex3_op;
  logic [11:0]              ex3_csr_addr;
  logic                     ex3_rs1_is_x0;
  logic                     ex3_rs2_is_x0;
  logic                     ex3_is_sfence;
  logic                     ex3_rd_valid;
  logic [RNID_W-1:0]        ex3_rd_rnid;
  logic [VADDR_W-1:0]       ex3_vaddr;
  logic [XLEN-1:0]          ex3_old;
  logic [XLEN-1:0]          ex3_new;
  logic                     ex3_illegal;

  logic            fwd_hit;
  logic [XLEN-1:0] fwd_sel;
  logic [XLEN-1:0] ex2_src;
  logic [XLEN-1:0] ex2_new;

  always_comb begin
    ex0_uop = '{index:     i_ex0_index,
                cmt_id:    i_ex0_cmt_id,
                op:        i_ex0_op,
                csr_addr:  i_ex0_csr_addr,
                rs1_valid: i_ex0_rs1_valid,
                rs1_rnid:  i_ex0_rs1_rnid,
                uimm:      i_ex0_uimm,
                rs1_is_x0: i_ex0_rs1_is_x0,
                rs2_is_x0: i_ex0_rs2_is_x0,
                is_sfence: i_ex0_is_sfence,
                rd_valid:  i_ex0_rd_valid,
                rd_rnid:   i_ex0_rd_rnid};
  end

  // Scan from the highest bus down so the lowest matching bus is left selected.
  always_comb begin
    fwd_hit = 1'b0;
    fwd_sel = '0;
    for (int k = TGT_BUS_SIZE - 1; k >= 0; k--) begin
      if (i_fwd_valid[k] && (i_fwd_rnid[k*RNID_W +: RNID_W] == ex2_uop.rs1_rnid)) begin
        fwd_hit = 1'b1;
        fwd_sel = i_fwd_data[k*XLEN +: XLEN];
      end
    end
    if (ex2_uop.rs1_rnid == '0) begin
      fwd_hit = 1'b0;
    end
  end

  always_comb begin
    ex2_src = i_ex2_rs1_data;
    if (!ex2_uop.rs1_valid) begin
      ex2_src = {{(XLEN-5){1'b0}}, ex2_uop.uimm};
    end else if (fwd_hit) begin
      ex2_src = fwd_sel;
    end
  end

  always_comb begin
    ex2_new = '0;
    case (ex2_uop.op)
      2'd1:    ex2_new = ex2_src;
      2'd2:    ex2_new = i_csr_rd_data | ex2_src;
      2'd3:    ex2_new = i_csr_rd_data & ~ex2_src;
      default: ex2_new = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      ex1_valid     <= 1'b0;
      ex2_valid     <= 1'b0;
      ex3_valid     <= 1'b0;
      ex1_uop       <= '0;
      ex2_uop       <= '0;
      ex3_index     <= '0;
      ex3_cmt_id    <= '0;
      ex3_op        <= '0;
      ex3_csr_addr  <= '0;
      ex3_rs1_is_x0 <= 1'b0;
      ex3_rs2_is_x0 <= 1'b0;
      ex3_is_sfence <= 1'b0;
      ex3_rd_valid  <= 1'b0;
      ex3_rd_rnid   <= '0;
      ex3_vaddr     <= '0;
      ex3_old       <= '0;
      ex3_new       <= '0;
      ex3_illegal   <= 1'b0;
    end else begin
      ex1_valid     <= i_ex0_valid & ~i_flush;
      ex2_valid     <= ex1_valid & ~i_flush;
      ex3_valid     <= ex2_valid & ~i_flush;
      ex1_uop       <= ex0_uop;
      ex2_uop       <= ex1_uop;
      ex3_index     <= ex2_uop.index;
      ex3_cmt_id    <= ex2_uop.cmt_id;
      ex3_op        <= ex2_uop.op;
      ex3_csr_addr  <= ex2_uop.csr_addr;
      ex3_rs1_is_x0 <= ex2_uop.rs1_is_x0;
      ex3_rs2_is_x0 <= ex2_uop.rs2_is_x0;
      ex3_is_sfence <= ex2_uop.is_sfence;
      ex3_rd_valid  <= ex2_uop.rd_valid;
      ex3_rd_rnid   <= ex2_uop.rd_rnid;
      ex3_vaddr     <= ex2_src[VADDR_W-1:0];
      ex3_old       <= i_csr_rd_data;
      ex3_new       <= ex2_new;
      ex3_illegal   <= ex2_valid & i_csr_rd_error;
    end
  end

  assign o_ex1_rs1_rd_valid = ex1_valid & ex1_uop.rs1_valid;
  assign o_ex1_rs1_rnid     = ex1_uop.rs1_rnid;
  assign o_csr_rd_valid     = ex2_valid & (ex2_uop.op != OP_NONE);
  assign o_csr_rd_addr      = ex2_uop.csr_addr;

  // Set/clear with a zero source leave the CSR untouched, so no write is issued.
  assign o_csr_wr_valid = ex3_valid & (ex3_op != OP_NONE) & ~ex3_illegal &
                          ~(((ex3_op == OP_RS) | (ex3_op == OP_RC)) & ex3_rs1_is_x0);
  assign o_csr_wr_addr  = ex3_csr_addr;
  assign o_csr_wr_data  = ex3_new;
  assign o_ex3_wr_valid = ex3_valid & ex3_rd_valid & ~ex3_illegal;
  assign o_ex3_wr_rnid  = ex3_rd_rnid;
  assign o_ex3_wr_data  = ex3_old;
  assign o_ex3_done     = ex3_valid;
  assign o_ex3_index    = ex3_valid ? ex3_index : '0;

  always_comb begin
    o_ex3_except = 2'd0;
    if (ex3_valid) begin
      if (ex3_illegal) begin
        o_ex3_except = 2'd2;
      end else if (o_csr_wr_valid || ex3_is_sfence) begin
        o_ex3_except = 2'd1;
      end
    end
  end

  logic [CMT_ID_W-1:0] sfq_cmt_id [SFQ_DEPTH];
  logic [VADDR_W-1:0]  sfq_vaddr  [SFQ_DEPTH];
  logic                sfq_rs1_x0 [SFQ_DEPTH];
  logic                sfq_rs2_x0 [SFQ_DEPTH];
  logic [PW-1:0]       sfq_head, sfq_tail;
  logic [CW-1:0]       sfq_count;
  logic                sfq_push, sfq_pop;
  logic [CW+1:0]       credit_used;

  assign sfq_push = ex3_valid & ex3_is_sfence & ~ex3_illegal;
  assign sfq_pop  = (sfq_count != '0) & i_commit_valid &
                    (sfq_cmt_id[sfq_head] == i_commit_cmt_id);

  // Storage carries no reset; every read of it is qualified by the count.
  always_ff @(posedge i_clk) begin
    if (sfq_push) begin
      sfq_cmt_id[sfq_tail] <= ex3_cmt_id;
      sfq_vaddr[sfq_tail]  <= ex3_vaddr;
      sfq_rs1_x0[sfq_tail] <= ex3_rs1_is_x0;
      sfq_rs2_x0[sfq_tail] <= ex3_rs2_is_x0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n || i_flush) begin
      sfq_head  <= '0;
      sfq_tail  <= '0;
      sfq_count <= '0;
    end else begin
      if (sfq_push) sfq_tail <= sfq_tail + 1'b1;
      if (sfq_pop)  sfq_head <= sfq_head + 1'b1;
      sfq_count <= sfq_count + CW'(sfq_push) - CW'(sfq_pop);
    end
  end

  assign o_sfence_valid  = sfq_pop;
  assign o_sfence_vaddr  = sfq_pop ? sfq_vaddr[sfq_head]  : '0;
  assign o_sfence_rs1_x0 = sfq_pop & sfq_rs1_x0[sfq_head];
  assign o_sfence_rs2_x0 = sfq_pop & sfq_rs2_x0[sfq_head];

  // Queued entries plus sfences still in flight must fit in the queue.
  assign credit_used = (CW+2)'(sfq_count) +
                       (CW+2)'(ex1_valid & ex1_uop.is_sfence) +
                       (CW+2)'(ex2_valid & ex2_uop.is_sfence) +
                       (CW+2)'(ex3_valid & ex3_is_sfence);
  assign o_sfence_credit_ok = i_reset_n & (credit_used < (CW+2)'(SFQ_DEPTH));

  a_sfence_credit: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    (i_ex0_valid && i_ex0_is_sfence) |-> o_sfence_credit_ok);

endmodule

// File: tb/tb_msrh_csu_pipe_mq.sv
// Self-checking bench for msrh_csu_pipe_mq: directed CSR/forward/illegal/SFQ/flush
// scenarios plus randomized back-to-back CSR traffic against a reference model.
module tb_msrh_csu_pipe_mq;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         i_ex0_valid;
  logic [31:0]  i_ex0_index;
  logic [5:0]   i_ex0_cmt_id;
  logic [1:0]   i_ex0_op;
  logic [11:0]  i_ex0_csr_addr;
  logic         i_ex0_rs1_valid;
  logic [6:0]   i_ex0_rs1_rnid;
  logic [4:0]   i_ex0_uimm;
  logic         i_ex0_rs1_is_x0, i_ex0_rs2_is_x0, i_ex0_is_sfence, i_ex0_rd_valid;
  logic [6:0]   i_ex0_rd_rnid;
  logic         o_ex1_rs1_rd_valid;
  logic [6:0]   o_ex1_rs1_rnid;
  logic [63:0]  i_ex2_rs1_data;
  logic [3:0]   i_fwd_valid;
  logic [27:0]  i_fwd_rnid;
  logic [255:0] i_fwd_data;
  logic         o_csr_rd_valid;
  logic [11:0]  o_csr_rd_addr;
  logic [63:0]  i_csr_rd_data;
  logic         i_csr_rd_error;
  logic         o_csr_wr_valid;
  logic [11:0]  o_csr_wr_addr;
  logic [63:0]  o_csr_wr_data;
  logic         o_ex3_wr_valid;
  logic [6:0]   o_ex3_wr_rnid;
  logic [63:0]  o_ex3_wr_data;
  logic         o_ex3_done;
  logic [31:0]  o_ex3_index;
  logic [1:0]   o_ex3_except;
  logic         i_commit_valid;
  logic [5:0]   i_commit_cmt_id;
  logic         i_flush;
  logic         o_sfence_credit_ok, o_sfence_valid;
  logic [38:0]  o_sfence_vaddr;
  logic         o_sfence_rs1_x0, o_sfence_rs2_x0;

  msrh_csu_pipe_mq dut (
    .i_clk(clk), .i_reset_n(reset_n),
    .i_ex0_valid(i_ex0_valid), .i_ex0_index(i_ex0_index), .i_ex0_cmt_id(i_ex0_cmt_id),
    .i_ex0_op(i_ex0_op), .i_ex0_csr_addr(i_ex0_csr_addr), .i_ex0_rs1_valid(i_ex0_rs1_valid),
    .i_ex0_rs1_rnid(i_ex0_rs1_rnid), .i_ex0_uimm(i_ex0_uimm), .i_ex0_rs1_is_x0(i_ex0_rs1_is_x0),
    .i_ex0_rs2_is_x0(i_ex0_rs2_is_x0), .i_ex0_is_sfence(i_ex0_is_sfence),
    .i_ex0_rd_valid(i_ex0_rd_valid), .i_ex0_rd_rnid(i_ex0_rd_rnid),
    .o_ex1_rs1_rd_valid(o_ex1_rs1_rd_valid), .o_ex1_rs1_rnid(o_ex1_rs1_rnid),
    .i_ex2_rs1_data(i_ex2_rs1_data), .i_fwd_valid(i_fwd_valid), .i_fwd_rnid(i_fwd_rnid),
    .i_fwd_data(i_fwd_data), .o_csr_rd_valid(o_csr_rd_valid), .o_csr_rd_addr(o_csr_rd_addr),
    .i_csr_rd_data(i_csr_rd_data), .i_csr_rd_error(i_csr_rd_error),
    .o_csr_wr_valid(o_csr_wr_valid), .o_csr_wr_addr(o_csr_wr_addr), .o_csr_wr_data(o_csr_wr_data),
    .o_ex3_wr_valid(o_ex3_wr_valid), .o_ex3_wr_rnid(o_ex3_wr_rnid), .o_ex3_wr_data(o_ex3_wr_data),
    .o_ex3_done(o_ex3_done), .o_ex3_index(o_ex3_index), .o_ex3_except(o_ex3_except),
    .i_commit_valid(i_commit_valid), .i_commit_cmt_id(i_commit_cmt_id), .i_flush(i_flush),
    .o_sfence_credit_ok(o_sfence_credit_ok), .o_sfence_valid(o_sfence_valid),
    .o_sfence_vaddr(o_sfence_vaddr), .o_sfence_rs1_x0(o_sfence_rs1_x0),
    .o_sfence_rs2_x0(o_sfence_rs2_x0)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit [1:0] op; bit rs1_valid; bit [6:0] rnid; bit [4:0] uimm; bit rs1_x0;
    bit rd_valid; bit [6:0] rd_rnid; bit [11:0] addr; bit [31:0] idx; bit [5:0] cmt;
    bit sf; bit rs2_x0; bit [63:0] regdata; bit [3:0] fv; bit [3:0][6:0] frn;
    bit [3:0][63:0] fd; bit [63:0] old; bit err;
  } txn_t;

  typedef struct {
    bit rd_req; bit [6:0] rd_rnid; bit csr_rd; bit [11:0] csr_rd_addr; bit done;
    bit [31:0] index; bit [1:0] except; bit cwv; bit [11:0] cwa; bit [63:0] cwd;
    bit wv; bit [6:0] wrn; bit [63:0] wd;
  } obs_t;

  typedef struct { bit [63:0] src; bit [63:0] nv; bit cwv; bit wv; bit [1:0] except; } exp_t;
  typedef struct { bit [5:0] cmt; bit [38:0] va; bit r1; bit r2; } sfq_t;

  txn_t tx[64];
  obs_t obs[64];
  txn_t nul;
  int   ntx;
  int   stray;
  sfq_t sfq_m[$];
  int   checks = 0;
  int   errors = 0;

  // Reference behaviour of one instruction, straight from the CSR-op rules.
  function automatic exp_t model(input txn_t t);
    exp_t e;
    e.src = t.regdata;
    if (!t.rs1_valid) e.src = 64'(t.uimm);
    else if (t.rnid != 0) begin
      for (int k = 0; k < 4; k++)
        if (t.fv[k] && t.frn[k] == t.rnid) begin e.src = t.fd[k]; break; end
    end
    case (t.op)
      2'd1: e.nv = e.src;
      2'd2: e.nv = t.old | e.src;
      2'd3: e.nv = t.old & ~e.src;
      default: e.nv = 64'd0;
    endcase
    e.cwv = (t.op != 0) && !t.err && !((t.op == 2 || t.op == 3) && t.rs1_x0);
    e.wv  = t.rd_valid && !t.err;
    e.except = t.err ? 2'd2 : ((e.cwv || t.sf) ? 2'd1 : 2'd0);
    return e;
  endfunction

  task automatic drive_ex0(input txn_t t, input bit v);
    i_ex0_valid = v; i_ex0_index = t.idx; i_ex0_cmt_id = t.cmt; i_ex0_op = t.op;
    i_ex0_csr_addr = t.addr; i_ex0_rs1_valid = t.rs1_valid; i_ex0_rs1_rnid = t.rnid;
    i_ex0_uimm = t.uimm; i_ex0_rs1_is_x0 = t.rs1_x0; i_ex0_rs2_is_x0 = t.rs2_x0;
    i_ex0_is_sfence = t.sf; i_ex0_rd_valid = t.rd_valid; i_ex0_rd_rnid = t.rd_rnid;
  endtask

  task automatic drive_ex2(input txn_t t);
    i_ex2_rs1_data = t.regdata; i_fwd_valid = t.fv; i_fwd_rnid = t.frn;
    i_fwd_data = t.fd; i_csr_rd_data = t.old; i_csr_rd_error = t.err;
  endtask

  // Issues tx[0..ntx-1] back to back, feeding EX2-side data two cycles after
  // each issue and recording what every stage shows for each instruction.
  task automatic run_pipe();
    stray = 0;
    for (int c = 0; c < ntx + 3; c++) begin
      @(negedge clk);
      if (c < ntx) drive_ex0(tx[c], 1'b1); else drive_ex0(nul, 1'b0);
      if (c >= 2 && c - 2 < ntx) drive_ex2(tx[c-2]); else drive_ex2(nul);
      #1;
      if (c >= 1 && c - 1 < ntx) begin
        obs[c-1].rd_req = o_ex1_rs1_rd_valid; obs[c-1].rd_rnid = o_ex1_rs1_rnid;
      end
      if (c >= 2 && c - 2 < ntx) begin
        obs[c-2].csr_rd = o_csr_rd_valid; obs[c-2].csr_rd_addr = o_csr_rd_addr;
      end
      if (c >= 3) begin
        obs[c-3].done = o_ex3_done; obs[c-3].index = o_ex3_index; obs[c-3].except = o_ex3_except;
        obs[c-3].cwv = o_csr_wr_valid; obs[c-3].cwa = o_csr_wr_addr; obs[c-3].cwd = o_csr_wr_data;
        obs[c-3].wv = o_ex3_wr_valid; obs[c-3].wrn = o_ex3_wr_rnid; obs[c-3].wd = o_ex3_wr_data;
      end else if (o_ex3_done) stray++;
    end
    @(negedge clk);
    drive_ex0(nul, 1'b0); drive_ex2(nul);
    #1;
    if (o_ex3_done) stray++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; i_flush = 1'b0; i_commit_valid = 1'b1; i_commit_cmt_id = 6'd0;
    drive_ex0(nul, 1'b0); drive_ex2(nul);
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({o_ex1_rs1_rd_valid, o_ex1_rs1_rnid, o_csr_rd_valid, o_csr_rd_addr, o_csr_wr_valid,
         o_csr_wr_addr, o_csr_wr_data, o_ex3_wr_valid, o_ex3_wr_rnid, o_ex3_wr_data, o_ex3_done,
         o_ex3_index, o_ex3_except, o_sfence_credit_ok, o_sfence_valid, o_sfence_vaddr,
         o_sfence_rs1_x0, o_sfence_rs2_x0} !== '0) begin
      errors++; $display("FAIL reset_outputs: some output is nonzero or X during reset (credit=%b done=%b)",
                         o_sfence_credit_ok, o_ex3_done);
    end
    @(negedge clk); reset_n = 1'b1; i_commit_valid = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (o_sfence_credit_ok !== 1'b1) begin
      errors++; $display("FAIL reset_credit: got %b expected 1", o_sfence_credit_ok);
    end
    checks++;
    if (o_sfence_valid !== 1'b0 || o_ex3_done !== 1'b0) begin
      errors++; $display("FAIL reset_idle: sfence_valid=%b done=%b expected 0 0", o_sfence_valid, o_ex3_done);
    end
  endtask

  task automatic test_csrrw();
    tx[0] = nul; tx[0].op = 1; tx[0].rs1_valid = 1; tx[0].rnid = 5; tx[0].regdata = 64'hA5;
    tx[0].old = 64'h10; tx[0].rd_valid = 1; tx[0].rd_rnid = 12; tx[0].addr = 12'h340;
    tx[0].idx = 32'h8;
    ntx = 1; run_pipe();
    checks++; if (obs[0].rd_req !== 1'b1 || obs[0].rd_rnid !== 7'd5) begin
      errors++; $display("FAIL rw_ex1_read: got %b/%0d expected 1/5", obs[0].rd_req, obs[0].rd_rnid); end
    checks++; if (obs[0].csr_rd !== 1'b1 || obs[0].csr_rd_addr !== 12'h340) begin
      errors++; $display("FAIL rw_csr_read: got %b/%h expected 1/340", obs[0].csr_rd, obs[0].csr_rd_addr); end
    checks++; if (obs[0].done !== 1'b1 || obs[0].index !== 32'h8 || stray !== 0) begin
      errors++; $display("FAIL rw_done_latency: done=%b index=%h stray=%0d expected 1 8 0",
                         obs[0].done, obs[0].index, stray); end
    checks++; if (obs[0].wv !== 1'b1 || obs[0].wrn !== 7'd12 || obs[0].wd !== 64'h10) begin
      errors++; $display("FAIL rw_writeback: got %b/%0d/%h expected 1/12/10", obs[0].wv, obs[0].wrn, obs[0].wd); end
    checks++; if (obs[0].cwv !== 1'b1 || obs[0].cwa !== 12'h340 || obs[0].cwd !== 64'hA5) begin
      errors++; $display("FAIL rw_csr_write: got %b/%h/%h expected 1/340/a5", obs[0].cwv, obs[0].cwa, obs[0].cwd); end
    checks++; if (obs[0].except !== 2'd1) begin
      errors++; $display("FAIL rw_except: got %0d expected 1", obs[0].except); end
  endtask

  task automatic test_csrrs_rc();
    tx[0] = nul; tx[0].op = 2; tx[0].rs1_valid = 1; tx[0].rnid = 0; tx[0].rs1_x0 = 1;
    tx[0].old = 64'h77; tx[0].rd_valid = 1; tx[0].rd_rnid = 4; tx[0].idx = 32'h1;
    tx[1] = nul; tx[1].op = 3; tx[1].rs1_valid = 0; tx[1].uimm = 5'h3;
    tx[1].old = 64'hF; tx[1].rd_valid = 1; tx[1].rd_rnid = 6; tx[1].idx = 32'h2;
    ntx = 2; run_pipe();
    checks++; if (obs[0].cwv !== 1'b0 || obs[0].wd !== 64'h77 || obs[0].except !== 2'd0) begin
      errors++; $display("FAIL rs_x0: cwv=%b wd=%h except=%0d expected 0 77 0", obs[0].cwv, obs[0].wd, obs[0].except); end
    checks++; if (obs[1].rd_req !== 1'b0) begin
      errors++; $display("FAIL rc_uimm_no_read: got %b expected 0", obs[1].rd_req); end
    checks++; if (obs[1].wd !== 64'hF || obs[1].cwv !== 1'b1 || obs[1].cwd !== 64'hC) begin
      errors++; $display("FAIL rc_uimm: wd=%h cwv=%b cwd=%h expected f 1 c", obs[1].wd, obs[1].cwv, obs[1].cwd); end
    checks++; if (obs[1].except !== 2'd1) begin
      errors++; $display("FAIL rc_except: got %0d expected 1", obs[1].except); end
  endtask

  task automatic test_forward();
    tx[0] = nul; tx[0].op = 1; tx[0].rs1_valid = 1; tx[0].rnid = 9; tx[0].regdata = 64'h5;
    tx[0].fv = 4'b1010; tx[0].frn[1] = 9; tx[0].frn[3] = 9; tx[0].fd[1] = 64'h1; tx[0].fd[3] = 64'h3;
    tx[1] = nul; tx[1].op = 1; tx[1].rs1_valid = 1; tx[1].rnid = 0; tx[1].regdata = 64'h22;
    tx[1].fv = 4'b0001; tx[1].frn[0] = 0; tx[1].fd[0] = 64'hDEAD;
    tx[2] = nul; tx[2].op = 1; tx[2].rs1_valid = 1; tx[2].rnid = 8; tx[2].regdata = 64'h33;
    tx[2].fv = 4'b0100; tx[2].frn[2] = 9; tx[2].fd[2] = 64'h44;
    ntx = 3; run_pipe();
    checks++; if (obs[0].cwd !== 64'h1) begin
      errors++; $display("FAIL fwd_lowest_bus: got %h expected 1", obs[0].cwd); end
    checks++; if (obs[1].cwd !== 64'h22) begin
      errors++; $display("FAIL fwd_rnid0: got %h expected 22", obs[1].cwd); end
    checks++; if (obs[2].cwd !== 64'h33) begin
      errors++; $display("FAIL fwd_miss: got %h expected 33", obs[2].cwd); end
  endtask

  task automatic test_illegal();
    tx[0] = nul; tx[0].op = 1; tx[0].rs1_valid = 0; tx[0].uimm = 5'h9; tx[0].rd_valid = 1;
    tx[0].rd_rnid = 2; tx[0].err = 1; tx[0].idx = 32'h80000000;
    ntx = 1; run_pipe();
    checks++; if (obs[0].except !== 2'd2 || obs[0].cwv !== 1'b0 || obs[0].wv !== 1'b0) begin
      errors++; $display("FAIL illegal: except=%0d cwv=%b wv=%b expected 2 0 0", obs[0].except, obs[0].cwv, obs[0].wv); end
    checks++; if (obs[0].done !== 1'b1 || obs[0].index !== 32'h80000000) begin
      errors++; $display("FAIL illegal_done: done=%b index=%h expected 1 80000000", obs[0].done, obs[0].index); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    ntx = 40;
    for (int i = 0; i < ntx; i++) begin
      tx[i] = nul;
      tx[i].op = 2'($urandom_range(0, 3)); tx[i].rs1_valid = ($urandom_range(0, 3) != 0);
      tx[i].rnid = 7'($urandom_range(0, 3)); tx[i].uimm = 5'($urandom_range(0, 31));
      tx[i].rs1_x0 = 1'($urandom_range(0, 1)); tx[i].rd_valid = 1'($urandom_range(0, 1));
      tx[i].rd_rnid = 7'($urandom_range(0, 127)); tx[i].addr = 12'($urandom_range(0, 4095));
      tx[i].idx = 32'd1 << $urandom_range(0, 31); tx[i].regdata = {$urandom, $urandom};
      tx[i].fv = 4'($urandom_range(0, 15)); tx[i].old = {$urandom, $urandom};
      tx[i].err = ($urandom_range(0, 7) == 0);
      for (int k = 0; k < 4; k++) begin
        tx[i].frn[k] = 7'($urandom_range(0, 3)); tx[i].fd[k] = {$urandom, $urandom};
      end
    end
    run_pipe();
    checks++; if (stray !== 0) begin
      errors++; $display("FAIL b2b_stray_done: got %0d expected 0", stray); end
    for (int i = 0; i < ntx; i++) begin
      e = model(tx[i]);
      checks++;
      if (obs[i].rd_req !== tx[i].rs1_valid || obs[i].csr_rd !== (tx[i].op != 0) ||
          obs[i].csr_rd_addr !== tx[i].addr || obs[i].done !== 1'b1 || obs[i].index !== tx[i].idx) begin
        errors++; $display("FAIL b2b_ctrl[%0d]: rd=%b csr_rd=%b addr=%h done=%b idx=%h expected %b %b %h 1 %h",
          i, obs[i].rd_req, obs[i].csr_rd, obs[i].csr_rd_addr, obs[i].done, obs[i].index,
          tx[i].rs1_valid, tx[i].op != 0, tx[i].addr, tx[i].idx);
      end
      checks++;
      if (obs[i].cwv !== e.cwv || obs[i].cwa !== tx[i].addr || obs[i].except !== e.except) begin
        errors++; $display("FAIL b2b_csr_wr[%0d]: cwv=%b addr=%h except=%0d expected %b %h %0d",
          i, obs[i].cwv, obs[i].cwa, obs[i].except, e.cwv, tx[i].addr, e.except);
      end
      if (tx[i].op != 0) begin
        checks++;
        if (obs[i].cwd !== e.nv) begin
          errors++; $display("FAIL b2b_wr_data[%0d]: got %h expected %h", i, obs[i].cwd, e.nv);
        end
      end
      checks++;
      if (obs[i].wv !== e.wv || obs[i].wrn !== tx[i].rd_rnid || obs[i].wd !== tx[i].old) begin
        errors++; $display("FAIL b2b_writeback[%0d]: %b/%0d/%h expected %b/%0d/%h",
          i, obs[i].wv, obs[i].wrn, obs[i].wd, e.wv, tx[i].rd_rnid, tx[i].old);
      end
    end
  endtask

  task automatic test_sfq();
    int ids[3] = '{3, 7, 4};
    bit exp_v;
    sfq_t s;
    checks++; if (o_sfence_credit_ok !== 1'b1) begin
      errors++; $display("FAIL sfq_credit_empty: got %b expected 1", o_sfence_credit_ok); end
    ntx = 4;
    for (int i = 0; i < 4; i++) begin
      tx[i] = nul; tx[i].sf = 1; tx[i].cmt = 6'(3 + i); tx[i].rs1_valid = 1;
      tx[i].rnid = 7'(10 + i); tx[i].regdata = {$urandom, $urandom};
      tx[i].rs1_x0 = 1'($urandom_range(0, 1)); tx[i].rs2_x0 = 1'($urandom_range(0, 1));
      tx[i].idx = 32'd1 << i;
    end
    run_pipe();
    for (int i = 0; i < 4; i++) begin
      s.cmt = tx[i].cmt; s.va = tx[i].regdata[38:0]; s.r1 = tx[i].rs1_x0; s.r2 = tx[i].rs2_x0;
      sfq_m.push_back(s);
      checks++;
      if (obs[i].except !== 2'd1 || obs[i].cwv !== 1'b0 || obs[i].done !== 1'b1) begin
        errors++; $display("FAIL sfq_sfence_ex3[%0d]: except=%0d cwv=%b done=%b expected 1 0 1",
                           i, obs[i].except, obs[i].cwv, obs[i].done);
      end
    end
    checks++; if (o_sfence_credit_ok !== 1'b0) begin
      errors++; $display("FAIL sfq_credit_full: got %b expected 0", o_sfence_credit_ok); end
    foreach (ids[j]) begin
      @(negedge clk); i_commit_valid = 1'b1; i_commit_cmt_id = 6'(ids[j]);
      #1;
      exp_v = (sfq_m.size() != 0) && (sfq_m[0].cmt == 6'(ids[j]));
      checks++;
      if (o_sfence_valid !== exp_v) begin
        errors++; $display("FAIL sfq_commit_%0d: sfence_valid=%b expected %b", ids[j], o_sfence_valid, exp_v);
      end else if (exp_v) begin
        checks++;
        if (o_sfence_vaddr !== sfq_m[0].va || o_sfence_rs1_x0 !== sfq_m[0].r1 || o_sfence_rs2_x0 !== sfq_m[0].r2) begin
          errors++; $display("FAIL sfq_head_%0d: va=%h x0=%b%b expected %h %b%b", ids[j], o_sfence_vaddr,
            o_sfence_rs1_x0, o_sfence_rs2_x0, sfq_m[0].va, sfq_m[0].r1, sfq_m[0].r2);
        end
      end
      @(negedge clk); i_commit_valid = 1'b0;
      if (exp_v) void'(sfq_m.pop_front());
      #1;
      checks++;
      if (o_sfence_credit_ok !== (sfq_m.size() < 4)) begin
        errors++; $display("FAIL sfq_credit_after_%0d: got %b expected %b", ids[j], o_sfence_credit_ok, sfq_m.size() < 4);
      end
    end
  endtask

  task automatic test_flush();
    txn_t a, s;
    bit exp_v;
    a = nul; a.op = 1; a.uimm = 5'h5; a.rd_valid = 1; a.rd_rnid = 3; a.addr = 12'h341;
    a.idx = 32'h10; a.old = 64'h1;
    s = nul; s.sf = 1; s.cmt = 8; s.uimm = 5'h1f;
    @(negedge clk); drive_ex0(a, 1'b1);
    @(negedge clk); drive_ex0(s, 1'b1);
    @(negedge clk); drive_ex0(nul, 1'b0); drive_ex2(a);
    @(negedge clk); drive_ex2(s); i_flush = 1'b1; i_commit_valid = 1'b1; i_commit_cmt_id = 6'd5;
    #1;
    exp_v = (sfq_m.size() == 2) && (sfq_m[0].cmt == 6'd5);
    checks++;
    if (o_ex3_done !== 1'b1 || o_csr_wr_valid !== 1'b1 || o_csr_wr_data !== 64'h5 || o_ex3_wr_data !== 64'h1) begin
      errors++; $display("FAIL flush_ex3_kept: done=%b cwv=%b cwd=%h wd=%h expected 1 1 5 1",
                         o_ex3_done, o_csr_wr_valid, o_csr_wr_data, o_ex3_wr_data);
    end
    checks++;
    if (o_sfence_valid !== exp_v || (exp_v && o_sfence_vaddr !== sfq_m[0].va)) begin
      errors++; $display("FAIL flush_commit_pop: valid=%b va=%h expected %b %h", o_sfence_valid,
                         o_sfence_vaddr, exp_v, sfq_m.size() != 0 ? sfq_m[0].va : 39'd0);
    end
    @(negedge clk); i_flush = 1'b0; i_commit_valid = 1'b0; drive_ex2(nul);
    sfq_m.delete();
    #1;
    checks++;
    if (o_ex3_done !== 1'b0 || o_ex3_except !== 2'd0 || o_sfence_credit_ok !== 1'b1) begin
      errors++; $display("FAIL flush_after: done=%b except=%0d credit=%b expected 0 0 1",
                         o_ex3_done, o_ex3_except, o_sfence_credit_ok);
    end
    for (int id = 6; id <= 8; id++) begin
      @(negedge clk); i_commit_valid = 1'b1; i_commit_cmt_id = 6'(id);
      #1;
      checks++;
      if (o_sfence_valid !== 1'b0) begin
        errors++; $display("FAIL flush_discarded_%0d: sfence_valid=%b expected 0", id, o_sfence_valid);
      end
    end
    @(negedge clk); i_commit_valid = 1'b0;
  endtask

  task automatic test_sfq_after_flush();
    tx[0] = nul; tx[0].sf = 1; tx[0].cmt = 9; tx[0].uimm = 5'h7; tx[0].rs1_x0 = 1; tx[0].idx = 32'h4;
    ntx = 1; run_pipe();
    @(negedge clk); i_commit_valid = 1'b1; i_commit_cmt_id = 6'd9;
    #1;
    checks++;
    if (o_sfence_valid !== 1'b1 || o_sfence_vaddr !== 39'h7 || o_sfence_rs1_x0 !== 1'b1 || o_sfence_rs2_x0 !== 1'b0) begin
      errors++; $display("FAIL refill_pop: valid=%b va=%h x0=%b%b expected 1 7 10", o_sfence_valid,
                         o_sfence_vaddr, o_sfence_rs1_x0, o_sfence_rs2_x0);
    end
    @(negedge clk); i_commit_valid = 1'b1;
    #1;
    checks++;
    if (o_sfence_valid !== 1'b0 || o_sfence_credit_ok !== 1'b1) begin
      errors++; $display("FAIL refill_empty: valid=%b credit=%b expected 0 1", o_sfence_valid, o_sfence_credit_ok);
    end
    @(negedge clk); i_commit_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_csrrw();
    test_csrrs_rc();
    test_forward();
    test_illegal();
    test_back_to_back();
    test_sfq();
    test_flush();
    test_sfq_after_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
